// File: rtl/demux_8bits_reg.sv
// Registered 1-to-2 stream demultiplexer: one input stream steered by a select bit
// into two one-entry output holding registers, each with a delivered-word counter.
module demux_8bits_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic             r_valid0;
    logic             r_valid1;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic w_room0;
    logic w_room1;
    logic w_hs_in;
    logic w_wr0;
    logic w_wr1;
    logic w_hs0;
    logic w_hs1;
    logic w_valid0_nxt;
    logic w_valid1_nxt;

    // A slot has room when empty or being drained this cycle; only the selected slot gates input.
    assign w_room0  = ~r_valid0 | out0_ready;
    assign w_room1  = ~r_valid1 | out1_ready;
    assign in_ready = in_sel ? w_room1 : w_room0;
    assign w_hs_in  = in_valid & in_ready;
    assign w_wr0    = w_hs_in & ~in_sel;
    assign w_wr1    = w_hs_in & in_sel;
    assign w_hs0    = r_valid0 & out0_ready;
    assign w_hs1    = r_valid1 & out1_ready;

    // Next-state valid flags: a new word wins over a drain so a refill has no bubble.
    always_comb begin
        w_valid0_nxt = r_valid0;
        w_valid1_nxt = r_valid1;
        if (w_wr0) begin
            w_valid0_nxt = 1'b1;
        end else if (w_hs0) begin
            w_valid0_nxt = 1'b0;
        end else begin
            w_valid0_nxt = r_valid0;
        end
        if (w_wr1) begin
            w_valid1_nxt = 1'b1;
        end else if (w_hs1) begin
            w_valid1_nxt = 1'b0;
        end else begin
            w_valid1_nxt = r_valid1;
        end
    end

    // Output holding registers and valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0  <= {WIDTH{1'b0}};
            r_data1  <= {WIDTH{1'b0}};
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid0 <= w_valid0_nxt;
            r_valid1 <= w_valid1_nxt;
            if (w_wr0) begin
                r_data0 <= in_data;
            end else begin
                r_data0 <= r_data0;
            end
            if (w_wr1) begin
                r_data1 <= in_data;
            end else begin
                r_data1 <= r_data1;
            end
        end
    end

    // Delivered-word counters; clear takes priority over a same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= {CNT_W{1'b0}};
            r_cnt1 <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            r_cnt0 <= {CNT_W{1'b0}};
            r_cnt1 <= {CNT_W{1'b0}};
        end else begin
            if (w_hs0) begin
                r_cnt0 <= r_cnt0 + CNT_ONE;
            end else begin
                r_cnt0 <= r_cnt0;
            end
            if (w_hs1) begin
                r_cnt1 <= r_cnt1 + CNT_ONE;
            end else begin
                r_cnt1 <= r_cnt1;
            end
        end
    end

    assign out0_data  = r_data0;
    assign out0_valid = r_valid0;
    assign out1_data  = r_data1;
    assign out1_valid = r_valid1;
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

endmodule
